// File: rtl/alu_pkg.sv
// ALU select codes and the divider's control states, shared by the combinational
// ALU and the sequential divide/remainder unit.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_REM  = 3'b100;
  localparam logic [2:0] ALU_CMP  = 3'b101;
  localparam logic [2:0] ALU_TEST = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract the divisor
// if it fits, and shift the resulting quotient bit into quo.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The true difference is below divisor, so a WIDTH-bit subtract is exact.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor});
    next_rem = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    next_quo = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned divide/remainder unit: valid/ready request in, one quotient
// bit per clock, valid/ready result out with zero and unsupported-op flags.
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             flagZ,
  output logic             err
);

  div_state_t       state, state_nx;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic [WIDTH-1:0] step_rem, step_quo, run_res, dz_res;
  logic             op_ok, last;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  always_comb begin
    op_ok   = (sel == ALU_DIV) || (sel == ALU_REM);
    dz_res  = (sel == ALU_DIV) ? {WIDTH{1'b1}} : A;
    run_res = (op == ALU_DIV) ? step_quo : step_rem;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (op_ok && (B != '0)) ? RUN : DONE;
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Results only load on completion, so C/flags hold through IDLE and RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      op    <= '0;
      C     <= '0;
      flagZ <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= sel;
            dvs_q <= B;
            if (!op_ok) begin
              rem_q <= '0;
              quo_q <= A;
              C     <= '0;
              flagZ <= 1'b1;
              err   <= 1'b1;
            end else if (B == '0) begin
              rem_q <= A;
              quo_q <= {WIDTH{1'b1}};
              C     <= dz_res;
              flagZ <= (dz_res == '0);
              err   <= 1'b0;
            end else begin
              rem_q <= '0;
              quo_q <= A;
              cnt   <= CNT_W'(WIDTH);
            end
          end
        end
        RUN: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt   <= cnt - CNT_W'(1);
          if (last) begin
            C     <= run_res;
            flagZ <= (run_res == '0);
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Randomized and directed bench for alu_seq_divider against an arithmetic model
// of the divide/remainder rules.
module tb_alu_seq_divider;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   sel = '0;
  logic         in_ready, out_valid, flagZ, err;
  logic [W-1:0] C;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .flagZ     (flagZ),
    .err       (err)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_c = '0;
  logic         exp_z = 1'b0;
  logic         exp_e = 1'b0;
  bit           exp_on = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference rules: unsupported op -> 0/err, divide by zero -> all ones or A,
  // otherwise plain integer / and %. lat = edges from acceptance to out_valid.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                                output logic [W-1:0] c, output logic z, output logic e,
                                output int lat);
    e   = 1'b0;
    lat = W;
    if (s != ALU_DIV && s != ALU_REM) begin
      c   = '0;
      e   = 1'b1;
      lat = 0;
    end else if (b == 0) begin
      c   = (s == ALU_DIV) ? {W{1'b1}} : a;
      lat = 0;
    end else begin
      c = (s == ALU_DIV) ? a / b : a % b;
    end
    z = (c == 0);
  endfunction

  // Every cycle a result is presented, it must match the model and hold still.
  always @(negedge clk) begin
    if (!rst && exp_on && out_valid) begin
      check("C", 64'(C), 64'(exp_c));
      check("flagZ", 64'(flagZ), 64'(exp_z));
      check("err", 64'(err), 64'(exp_e));
      check("done_in_ready", 64'(in_ready), 64'd0);
    end
  end

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                     input int stall, output logic [W-1:0] got_c, output logic got_z,
                     output logic got_e);
    logic [W-1:0] mc;
    logic         mz, me;
    int           lat, n, acc;
    model(a, b, s, mc, mz, me, lat);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    A = a;
    B = b;
    sel = s;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    sel = 3'($urandom);
    exp_c = mc;
    exp_z = mz;
    exp_e = me;
    exp_on = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(cyc - acc), 64'(lat));
    got_c = C;
    got_z = flagZ;
    got_e = err;
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        in_valid = ((i % 2) == 1);
        A = $urandom;
        B = $urandom | 1;
        sel = ALU_DIV;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_on = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_C_kept", 64'(C), 64'(mc));
  endtask

  logic [W-1:0] gc, ra, rb;
  logic         gz, ge;
  logic [2:0]   rs;
  int           rstall;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_C", 64'(C), 64'd0);
    check("rst_flagZ", 64'(flagZ), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(100, 7, ALU_DIV, 0, gc, gz, ge);
    check("lit_100div7", 64'(gc), 64'd14);
    check("lit_100div7_z", 64'(gz), 64'd0);
    check("lit_100div7_e", 64'(ge), 64'd0);
    run(100, 7, ALU_REM, 0, gc, gz, ge);
    check("lit_100rem7", 64'(gc), 64'd2);
    run(21, 7, ALU_REM, 0, gc, gz, ge);
    check("lit_21rem7", 64'(gc), 64'd0);
    check("lit_21rem7_z", 64'(gz), 64'd1);
    run(5, 0, ALU_DIV, 0, gc, gz, ge);
    check("lit_5div0", 64'(gc), 64'hFFFF_FFFF);
    check("lit_5div0_e", 64'(ge), 64'd0);
    run(5, 0, ALU_REM, 0, gc, gz, ge);
    check("lit_5rem0", 64'(gc), 64'd5);
    check("lit_5rem0_e", 64'(ge), 64'd0);
    run(77, 3, ALU_ADD, 0, gc, gz, ge);
    check("lit_badsel_C", 64'(gc), 64'd0);
    check("lit_badsel_z", 64'(gz), 64'd1);
    check("lit_badsel_e", 64'(ge), 64'd1);
    run(1000, 33, ALU_DIV, 10, gc, gz, ge);
    check("lit_bp_1000div33", 64'(gc), 64'd30);
    run(50, 5, ALU_DIV, 0, gc, gz, ge);
    check("lit_after_bp", 64'(gc), 64'd10);

    // Abort a long divide in its 10th RUN cycle.
    @(negedge clk);
    in_valid = 1'b1;
    A = 32'hFFFF_FFFF;
    B = 3;
    sel = ALU_DIV;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midrun_busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_C", 64'(C), 64'd0);
    check("abort_flagZ", 64'(flagZ), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(9, 2, ALU_DIV, 0, gc, gz, ge);
    check("lit_9div2", 64'(gc), 64'd4);

    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: begin
          if (rb == 0) rb = 1;
          ra = $urandom_range(0, rb - 1);
        end
        2: ra = rb;
        3: ra = '0;
        4: rb = 1;
        default: rb = $urandom_range(1, 255);
      endcase
      if (rb == 0) rb = 1;
      rs = ($urandom_range(0, 1) == 0) ? ALU_DIV : ALU_REM;
      rstall = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
      run(ra, rb, rs, rstall, gc, gz, ge);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
